// File: rtl/branch_addr_stack_ctrl.sv
// Control sequencer for a LIFO bank of tri-stated branch/return-address
// registers sharing one address bus: write enables, chip-selects, clear.
module branch_addr_stack_ctrl #(
    parameter int DEPTH    = 8,
    parameter int PTR_BITS = 3,
    parameter int CNT_BITS = 4
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Tick,
    input  logic                push_req,
    input  logic                pop_req,
    input  logic                flush,
    output logic [DEPTH-1:0]    reg_we,
    output logic [DEPTH-1:0]    reg_cs,
    output logic                reg_clr,
    output logic                push_ack,
    output logic                pop_ack,
    output logic [CNT_BITS-1:0] depth,
    output logic                empty,
    output logic                full,
    output logic                overflow,
    output logic                underflow
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        CLEAR
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_BITS-1:0] depth_q, depth_d;
    logic [DEPTH-1:0]    we_q, we_d;
    logic [DEPTH-1:0]    cs_q, cs_d;
    logic                pa_q, pa_d;
    logic                pp_q, pp_d;
    logic                clr_q, clr_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic [PTR_BITS-1:0] wr_idx;
    logic [PTR_BITS-1:0] top_idx;

    assign wr_idx  = PTR_BITS'(depth_q);
    assign top_idx = PTR_BITS'(depth_q - CNT_BITS'(1));

    assign empty = (depth_q == '0);
    assign full  = (depth_q == CNT_BITS'(DEPTH));

    // Every control output is decided one step ahead and registered.
    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        we_d    = '0;
        cs_d    = '1;
        pa_d    = 1'b0;
        pp_d    = 1'b0;
        clr_d   = 1'b0;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        unique case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = CLEAR;
                    clr_d   = 1'b1;
                end else if (push_req && !full) begin
                    state_d      = WRITE;
                    we_d[wr_idx] = 1'b1;
                    pa_d         = 1'b1;
                end else if (pop_req && !empty) begin
                    state_d       = READ;
                    cs_d[top_idx] = 1'b0;
                    pp_d          = 1'b1;
                end
                if (push_req && full)
                    ovf_d = 1'b1;
                if (pop_req && empty)
                    unf_d = 1'b1;
            end
            WRITE: begin
                depth_d = depth_q + CNT_BITS'(1);
                state_d = IDLE;
            end
            READ: begin
                depth_d = depth_q - CNT_BITS'(1);
                state_d = IDLE;
            end
            CLEAR: begin
                depth_d = '0;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            depth_q <= '0;
            we_q    <= '0;
            cs_q    <= '1;
            pa_q    <= 1'b0;
            pp_q    <= 1'b0;
            clr_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (Tick) begin
            state_q <= state_d;
            depth_q <= depth_d;
            we_q    <= we_d;
            cs_q    <= cs_d;
            pa_q    <= pa_d;
            pp_q    <= pp_d;
            clr_q   <= clr_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign reg_we    = we_q;
    assign reg_cs    = cs_q;
    assign reg_clr   = Reset | clr_q;
    assign push_ack  = pa_q;
    assign pop_ack   = pp_q;
    assign depth     = depth_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule
